// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM states, clog2.
// UART_RX_BREAK_DET_EN adds the break-wait state.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

`ifdef UART_RX_BREAK_DET_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} rx_state_e;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
`endif

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned v = 1; v < value; v = v << 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_rx_param_sync_fifo.sv
// First-word-fall-through receive FIFO with registered head output.
// Pointers carry one extra wrap bit so full/empty come from a plain compare.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = rdata_q;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) begin
         mem_d[wptr_q[AW-1:0]] = wdata;
         wptr_d                = wptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      // Head is taken from the post-update array so a push into an empty FIFO is visible at once.
      rdata_d = mem_d[rptr_d[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         rdata_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote, frame FSM, receive FIFO.
// Define UART_RX_BREAK_DET_EN to add the break_det output and the BREAK wait state.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 2600,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_uart,
   output logic [DATA_BITS-1:0] r_data,
   output logic                 rx_empty,
   output logic                 rx_full,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
`ifdef UART_RX_BREAK_DET_EN
   output logic                 break_det,
`endif
   output logic                 busy
);

   localparam int unsigned      CNT_W      = clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CENTRE_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] BIT_CNT    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);

   rx_state_e            state_q, state_d;
   logic                 sync1_q, sync1_d, sync2_q, sync2_d;
   logic                 prev_q, prev_d, prev2_q, prev2_d;
   logic [1:0]           valid_q, valid_d;
   logic                 armed_q, armed_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d, done_q, done_d;
   logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
   logic                 zero_q, zero_d, break_det_q, break_det_d;
`endif
   logic                 vote, tick, par_ok, pop_eff, push;

   assign vote    = (sync2_q & prev_q) | (sync2_q & prev2_q) | (prev_q & prev2_q);
   assign tick    = (cnt_q == '0);
   assign pop_eff = rd_uart && !rx_empty;
   assign push    = done_q && par_ok && (!rx_full || pop_eff);

   always_comb begin
      case (PARITY)
         PARITY_ODD:  par_ok = par_q;
         PARITY_EVEN: par_ok = !par_q;
         default:     par_ok = 1'b1;
      endcase
   end

   // Start detection is armed only once a real (post-reset) high has been seen on the line,
   // so a line held low through reset cannot fake a falling edge.
   always_comb begin
      sync1_d      = rx;
      sync2_d      = sync1_q;
      prev_d       = sync2_q;
      prev2_d      = prev_q;
      valid_d      = {valid_q[0], 1'b1};
      armed_d      = armed_q | (valid_q[1] & sync2_q);
      state_d      = state_q;
      cnt_d        = tick ? cnt_q : cnt_q - CNT_ONE;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      done_d       = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = done_q && !par_ok;
      overrun_d    = done_q && par_ok && rx_full && !pop_eff;
`ifdef UART_RX_BREAK_DET_EN
      zero_d       = zero_q;
      break_det_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (armed_q && prev_q && !sync2_q) begin
               state_d = ST_START;
               cnt_d   = CENTRE_CNT;
            end
         end
         ST_START: begin
            if (tick) begin
               cnt_d = BIT_CNT;
               bit_d = '0;
               par_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
               zero_d = 1'b1;
`endif
               state_d = vote ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               cnt_d   = BIT_CNT;
               shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
               par_d   = par_q ^ vote;
`ifdef UART_RX_BREAK_DET_EN
               zero_d  = zero_q & !vote;
`endif
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               cnt_d   = BIT_CNT;
               par_d   = par_q ^ vote;
`ifdef UART_RX_BREAK_DET_EN
               zero_d  = zero_q & !vote;
`endif
               bit_d   = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               cnt_d = BIT_CNT;
               if (!vote) begin
`ifdef UART_RX_BREAK_DET_EN
                  if (zero_q) begin
                     break_det_d = 1'b1;
                     state_d     = ST_BREAK;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_IDLE;
                  end
`else
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
`endif
               end else if (bit_q == LAST_STOP) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_BREAK_DET_EN
         ST_BREAK: begin
            if (sync2_q) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         prev2_q      <= 1'b1;
         valid_q      <= '0;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         done_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
         zero_q       <= 1'b0;
         break_det_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         prev2_q      <= prev2_d;
         valid_q      <= valid_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         done_q       <= done_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
         zero_q       <= zero_d;
         break_det_q  <= break_det_d;
`endif
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
   assign break_det  = break_det_q;
`endif

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop_eff),
      .wdata (shreg_q),
      .rdata (r_data),
      .empty (rx_empty),
      .full  (rx_full)
   );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 receiver share clk/reset; sel routes the line to one.
// Expected bytes and pulses come from a frame-level model holding a byte queue of the FIFO depth.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int C      = 16;
   localparam int CENTRE = C / 2;
   localparam int DEPTH  = 4;

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   logic rx_line = 1'b1;
   logic rd      = 1'b0;
   logic sel     = 1'b0;

   logic       rx0, rx1, rd0, rd1;
   logic [7:0] r_data0, r_data1, r_data_s;
   logic       e0, e1, f0, f1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;
   logic       rx_empty_s, rx_full_s, fe_s, pe_s, ov_s, busy_s;
`ifdef UART_RX_BREAK_DET_EN
   logic       bk0, bk1, bk_s;
`endif

   int total = 0;
   int bad   = 0;
   int n_fe  = 0;
   int n_pe  = 0;
   int n_ov  = 0;
   int n_bk  = 0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   assign rx0 = sel ? 1'b1 : rx_line;
   assign rx1 = sel ? rx_line : 1'b1;
   assign rd0 = sel ? 1'b0 : rd;
   assign rd1 = sel ? rd : 1'b0;

   assign r_data_s   = sel ? r_data1 : r_data0;
   assign rx_empty_s = sel ? e1 : e0;
   assign rx_full_s  = sel ? f1 : f0;
   assign fe_s       = sel ? fe1 : fe0;
   assign pe_s       = sel ? pe1 : pe0;
   assign ov_s       = sel ? ov1 : ov0;
   assign busy_s     = sel ? b1 : b0;
`ifdef UART_RX_BREAK_DET_EN
   assign bk_s       = sel ? bk1 : bk0;
`endif

   uart_rx_param #(
      .DATA_BITS (8), .CLKS_PER_BIT (C), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
   ) u_dut0 (
      .clk (clk), .reset (reset), .rx (rx0), .rd_uart (rd0), .r_data (r_data0),
      .rx_empty (e0), .rx_full (f0), .frame_err (fe0), .parity_err (pe0), .overrun (ov0),
`ifdef UART_RX_BREAK_DET_EN
      .break_det (bk0),
`endif
      .busy (b0)
   );

   uart_rx_param #(
      .DATA_BITS (8), .CLKS_PER_BIT (C), .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
   ) u_dut1 (
      .clk (clk), .reset (reset), .rx (rx1), .rd_uart (rd1), .r_data (r_data1),
      .rx_empty (e1), .rx_full (f1), .frame_err (fe1), .parity_err (pe1), .overrun (ov1),
`ifdef UART_RX_BREAK_DET_EN
      .break_det (bk1),
`endif
      .busy (b1)
   );

   always @(negedge clk) begin
      if (fe_s) n_fe++;
      if (pe_s) n_pe++;
      if (ov_s) n_ov++;
`ifdef UART_RX_BREAK_DET_EN
      if (bk_s) n_bk++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_one();
      @(negedge clk);
      check("pop_empty_flag", rx_empty_s, q.size() == 0);
      if (q.size() > 0) check("pop_data", r_data_s, q[0]);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   // One frame, one negedge per loop pass; negedge i drives bit i/C.  The receiver decides the
   // last bit at its centre+1 sample behind a 2-FF synchroniser, so the push cycle is negedge
   // 4 + last*C + CENTRE and rx_empty falls one negedge later.
   task automatic send_frame(input logic [7:0] data, input logic par_bad, input logic stop_bad,
                             input logic pop_at_push, input logic chk_time, input int reset_at);
      logic bits[$];
      logic pbit, exp_fe, exp_pe, exp_ov, exp_bk, aborted;
      int   last, popi, s_fe, s_pe, s_ov, s_bk;
      pbit    = 1'b0;
      exp_ov  = 1'b0;
      exp_bk  = 1'b0;
      aborted = 1'b0;
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(data[k]);
      if (sel) begin
         pbit = (^data) ^ par_bad;
         bits.push_back(pbit);
      end
      bits.push_back(~stop_bad);
      last   = bits.size() - 1;
      popi   = 4 + last * C + CENTRE;
      exp_fe = stop_bad;
      exp_pe = !stop_bad && sel && (($countones({data, pbit}) % 2) != 0);
`ifdef UART_RX_BREAK_DET_EN
      exp_bk = stop_bad && (data == 8'h00) && !pbit;
      exp_fe = stop_bad && !exp_bk;
`endif
      s_fe = n_fe;
      s_pe = n_pe;
      s_ov = n_ov;
      s_bk = n_bk;
      for (int i = 0; i < bits.size() * C; i++) begin
         @(negedge clk);
         if (reset_at >= 0 && i == reset_at + 1) begin
            check("reset_empty", rx_empty_s, 1);
            check("reset_busy", busy_s, 0);
            reset   = 1'b0;
            rx_line = 1'b1;
            q.delete();
            aborted = 1'b1;
            break;
         end
         if (i == reset_at) reset = 1'b1;
         if (i == popi) begin
            if (chk_time) check("empty_before_push", rx_empty_s, 1);
            if (pop_at_push) begin
               check("pop_at_push_data", r_data_s, q[0]);
               rd = 1'b1;
               void'(q.pop_front());
            end
            if (!exp_fe && !exp_pe && !exp_bk) begin
               if (q.size() < DEPTH) q.push_back(data);
               else exp_ov = 1'b1;
            end
         end
         if (i == popi + 1) begin
            rd = 1'b0;
            if (chk_time) begin
               check("empty_fall", rx_empty_s, 0);
               check("head_data", r_data_s, data);
            end
         end
         rx_line = bits[i / C];
      end
      if (aborted) begin
         repeat (2 * C) @(negedge clk);
      end else begin
`ifdef UART_RX_BREAK_DET_EN
         if (exp_bk) begin
            repeat (3 * C) @(negedge clk);
            check("break_hold_busy", busy_s, 1);
         end
`endif
         rx_line = 1'b1;
         repeat (8) @(negedge clk);
         check("frame_err_pulses", n_fe - s_fe, exp_fe);
         check("parity_err_pulses", n_pe - s_pe, exp_pe);
         check("overrun_pulses", n_ov - s_ov, exp_ov);
`ifdef UART_RX_BREAK_DET_EN
         check("break_pulses", n_bk - s_bk, exp_bk);
`endif
         check("idle_busy", busy_s, 0);
         check("empty_flag", rx_empty_s, q.size() == 0);
         check("full_flag", rx_full_s, q.size() == DEPTH);
      end
   endtask

   task automatic drain();
      while (q.size() > 0) pop_one();
      pop_one();
      @(negedge clk);
      check("drained_empty", rx_empty_s, 1);
   endtask

   initial begin
      int s_fe, s_pe, s_ov;
      repeat (3) @(negedge clk);
      check("rst_r_data0", r_data0, 0);
      check("rst_empty0", e0, 1);
      check("rst_full0", f0, 0);
      check("rst_busy0", b0, 0);
      check("rst_errs0", {fe0, pe0, ov0}, 0);
      check("rst_empty1", e1, 1);
      check("rst_busy1", b1, 0);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // 8N1 byte with exact rx_empty timing, then one pop
      sel = 1'b0;
      send_frame(8'h08, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      pop_one();
      @(negedge clk);
      check("empty_after_pop", rx_empty_s, 1);

      // short low glitch on the line
      s_fe = n_fe; s_pe = n_pe; s_ov = n_ov;
      rx_line = 1'b0;
      repeat (6) @(negedge clk);
      rx_line = 1'b1;
      repeat (2 * C) @(negedge clk);
      check("glitch_busy", busy_s, 0);
      check("glitch_empty", rx_empty_s, 1);
      check("glitch_errs", (n_fe - s_fe) + (n_pe - s_pe) + (n_ov - s_ov), 0);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      drain();

      // even parity: wrong then right parity bit
      sel = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      drain();
      sel = 1'b0;
      repeat (4) @(negedge clk);

      // framing error, plus break handling when built in
      send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, -1);
`ifdef UART_RX_BREAK_DET_EN
      send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
`endif
      drain();

      // overrun on the fifth byte, then the same with a pop on the push cycle
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b0, 1'b0, -1);
      drain();
      for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h05, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      drain();

      // reset mid-DATA with one byte buffered
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 3 * C);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      drain();

      // randomised traffic on both receivers
      for (int n = 0; n < 16; n++) begin
         logic sb;
         sb = ($urandom_range(0, 7) == 0);
         send_frame(8'($urandom), 1'b0, sb, (q.size() == DEPTH) && ($urandom_range(0, 1) == 1),
                    1'b0, -1);
         repeat ($urandom_range(0, 2)) pop_one();
      end
      drain();
      sel = 1'b1;
      repeat (4) @(negedge clk);
      for (int n = 0; n < 8; n++) begin
         logic pb, sb;
         pb = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 7) == 0);
         send_frame(8'($urandom), pb, sb, 1'b0, 1'b0, -1);
         repeat ($urandom_range(0, 1)) pop_one();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
